// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, 1-cycle IMEM issue, instruction queue, EX redirect flush.
// Optional macro IF_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault and fetch halt.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        ID_READY,
    output logic        VALID_IF,
    output logic [31:0] PC_IF,
    output logic [31:0] IDATA_IF,
    output logic [31:0] PC4_IF,
    output logic        FETCH_FAULT
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        kill;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0] pc_mem   [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];

    logic        halt;
    logic        issue;
    logic        push;
    logic        pop;
    logic [CW:0] credit;
    logic [31:0] target;

    assign target = {BR_TARGET[31:2], 2'b00};

`ifdef IF_MISALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fault_q <= 1'b0;
        end else if (BR_TAKEN && (BR_TARGET[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign halt        = fault_q;
    assign FETCH_FAULT = fault_q;
`else
    logic unused_tgt;
    assign unused_tgt  = ^BR_TARGET[1:0];
    assign halt        = 1'b0;
    assign FETCH_FAULT = 1'b0;
`endif

    // Credit counts the in-flight read so a response always finds a free slot.
    assign credit   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue    = RSTN & ~BR_TAKEN & ~halt & (credit < DEPTH_W);
    assign push     = inflight & ~kill & ~BR_TAKEN;
    assign VALID_IF = (count != '0);
    assign pop      = VALID_IF & ID_READY & ~BR_TAKEN;

    assign IMEM_REQ  = issue;
    assign IMEM_ADDR = fetch_pc;

    assign PC_IF    = VALID_IF ? pc_mem[rd_ptr] : 32'h0;
    assign IDATA_IF = VALID_IF ? data_mem[rd_ptr] : NOP;
    assign PC4_IF   = PC_IF + 32'd4;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            kill        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            kill <= BR_TAKEN & inflight;
            if (BR_TAKEN) begin
                fetch_pc <= target;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            data_mem[wr_ptr] <= IMEM_RDATA;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based fetch model.
module tb_if_fetch_queue;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        BR_TAKEN = 1'b0;
    logic [31:0] BR_TARGET = 32'h0;
    logic        ID_READY = 1'b0;
    logic        VALID_IF;
    logic [31:0] PC_IF;
    logic [31:0] IDATA_IF;
    logic [31:0] PC4_IF;
    logic        FETCH_FAULT;

    if_fetch_queue #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .ID_READY(ID_READY),
        .VALID_IF(VALID_IF), .PC_IF(PC_IF), .IDATA_IF(IDATA_IF),
        .PC4_IF(PC4_IF), .FETCH_FAULT(FETCH_FAULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] fpc;
    logic [31:0] ipc;
    bit          infl;
    bit          kill;
    bit          fault;
    bit          prev_req;
    logic [31:0] prev_addr;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic model_reset();
        q.delete();
        fpc = 32'h0;
        ipc = 32'h0;
        infl = 0;
        kill = 0;
        fault = 0;
        prev_req = 0;
        prev_addr = 32'h0;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'h0, VALID_IF}, 32'h0);
        check("rst_pc", PC_IF, 32'h0);
        check("rst_idata", IDATA_IF, 32'h0000_0013);
        check("rst_pc4", PC4_IF, 32'h4);
        check("rst_req", {31'h0, IMEM_REQ}, 32'h0);
        check("rst_fault", {31'h0, FETCH_FAULT}, 32'h0);
    endtask

    // Assert reset off-edge, check outputs at once, release just after a rising edge.
    task automatic do_reset();
        @(negedge CLK);
        #2 RSTN = 1'b0;
        BR_TAKEN = 1'b0;
        ID_READY = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge CLK);
        #1 check_reset_outputs();
        #1 RSTN = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit br, input logic [31:0] tgt, input bit rdy);
        bit          halt;
        bit          ereq;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] edat;
        @(negedge CLK);
        IMEM_RDATA = prev_req ? tag_of(prev_addr) : $urandom;
        BR_TAKEN = br;
        BR_TARGET = tgt;
        ID_READY = rdy;
        #1;
`ifdef IF_MISALIGN_CHECK_EN
        halt = fault;
`else
        halt = 0;
`endif
        ereq = !br && !halt && ((q.size() + int'(infl)) < DEPTH);
        ev = q.size() != 0;
        epc = ev ? q[0].pc : 32'h0;
        edat = ev ? q[0].d : 32'h0000_0013;
        check("valid", {31'h0, VALID_IF}, {31'h0, ev});
        check("pc", PC_IF, epc);
        check("idata", IDATA_IF, edat);
        check("pc4", PC4_IF, epc + 32'd4);
        check("req", {31'h0, IMEM_REQ}, {31'h0, ereq});
        if (ereq) check("addr", IMEM_ADDR, fpc);
        check("fault", {31'h0, FETCH_FAULT}, {31'h0, fault});
        prev_req = ereq;
        prev_addr = fpc;
        if (br) begin
            q.delete();
            kill = infl;
            infl = 0;
            fpc = {tgt[31:2], 2'b00};
`ifdef IF_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) fault = 1;
`endif
        end else begin
            if (ev && rdy) void'(q.pop_front());
            if (infl && !kill) q.push_back('{ipc, tag_of(ipc)});
            kill = 0;
            if (ereq) begin
                ipc = fpc;
                fpc = fpc + 32'd4;
                infl = 1;
            end else begin
                infl = 0;
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        unique case ($urandom_range(0, 5))
            0: return 32'h100;
            1: return 32'hFFFF_FFF8;
            2: return 32'h102;
            3: return $urandom;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        model_reset();
        #1 check_reset_outputs();
        do_reset();
        repeat (20) step(0, 32'h0, 1);
        repeat (5) step(0, 32'h0, 0);
        repeat (10) step(0, 32'h0, 1);
        repeat (3) step(0, 32'h0, 0);
        step(1, 32'h100, 0);
        repeat (10) step(0, 32'h0, 1);
        step(1, 32'hFFFF_FFF8, 1);
        repeat (4) step(0, 32'h0, 0);
        repeat (10) step(0, 32'h0, 1);
        step(1, 32'h200, 1);
        step(1, 32'h300, 1);
        repeat (6) step(0, 32'h0, 1);
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 11) == 0) step(1, pick_target(), $urandom_range(0, 1) == 1);
                else step(0, $urandom, $urandom_range(0, 9) < 7);
            end
            do_reset();
        end
        repeat (8) step(0, 32'h0, 1);
        step(1, 32'h102, 1);
        repeat (10) step(0, 32'h0, 1);
        step(1, 32'h400, 1);
        repeat (5) step(0, 32'h0, 1);
        do_reset();
        repeat (10) step(0, 32'h0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
